// File: rtl/dmem_if.sv
// Request/response bundle between the core load/store unit and the data memory.
// Request: valid/ready with store flag, funct3 size, byte address and store data.
// Response: valid/ready with load data and an access-fault flag.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised RV32I data memory serving byte-addressed loads/stores with fault checks.
// resp_valid rises exactly LATENCY cycles after the request accept edge.
// Holds the response until resp_ready; no new request is accepted until the handshake.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          l_we;
  logic [2:0]    l_size;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [32:0]   diff;
  logic [IW-1:0] idx;
  logic          size_ok;
  logic          misal;
  logic          range_bad;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [31:0]   wr_word;
  logic          access_edge;
  logic          wr_en;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  // Decode the latched request: fault checks, read extraction and store merge.
  always_comb begin
    // 33-bit subtraction so the borrow flags addresses below the base.
    diff      = {1'b0, l_addr} - {1'b0, BASE_ADDR};
    idx       = diff[IW+1:2];
    size_ok   = l_we ? (l_size inside {3'd0, 3'd1, 3'd2})
                     : (l_size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal     = ((l_size == 3'd1 || l_size == 3'd5) && l_addr[0]) ||
                ((l_size == 3'd2) && (l_addr[1:0] != 2'd0));
    range_bad = diff[32] || ({1'b0, diff[31:0]} >= SPAN);
    acc_err   = !size_ok || misal || range_bad;

    rd_word = mem[idx];
    rd_byte = rd_word[{l_addr[1:0], 3'b000} +: 8];
    rd_half = l_addr[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = rd_word;
    case (l_size)
      3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
      3'd4:    load_data = {24'h0, rd_byte};
      3'd5:    load_data = {16'h0, rd_half};
      default: load_data = rd_word;
    endcase

    wr_word = rd_word;
    case (l_size)
      3'd0: wr_word[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
      3'd1: begin
        if (l_addr[1]) wr_word[31:16] = l_wdata[15:0];
        else           wr_word[15:0]  = l_wdata[15:0];
      end
      3'd2:    wr_word = l_wdata;
      default: wr_word = rd_word;
    endcase

    // The edge leaving the last WAIT cycle is the entry edge into RESP.
    access_edge = (state == WAIT) && (cnt == '0);
    wr_en       = access_edge && l_we && !acc_err;
  end

  // RAM write port; contents survive reset, and reset forces IDLE so no write follows.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_word;
  end

  // Control FSM with registered handshake and response outputs.
  // The accept edge only latches the request, so WAIT always lasts LATENCY cycles
  // (a single cycle when LATENCY is 1) and the access lands on the RESP entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      l_we         <= 1'b0;
      l_size       <= 3'd0;
      l_addr       <= 32'h0;
      l_wdata      <= 32'h0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            l_we        <= bus.req_we;
            l_size      <= bus.req_size;
            l_addr      <= bus.req_addr;
            l_wdata     <= bus.req_wdata;
            cnt         <= CW'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= (acc_err || l_we) ? 32'h0 : load_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 2, 1, 4) through directed and random loads/stores.
// Expected data comes from a byte-addressed reference memory inside the bench.
// Timing, back-pressure hold and reset abort are checked at each step.
module tb_dmem_responder;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [2:0]  req_size   [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_if bus_i ();
    assign bus_i.req_valid  = req_valid[g];
    assign bus_i.req_we     = req_we[g];
    assign bus_i.req_size   = req_size[g];
    assign bus_i.req_addr   = req_addr[g];
    assign bus_i.req_wdata  = req_wdata[g];
    assign bus_i.resp_ready = resp_ready[g];
    assign req_ready[g]     = bus_i.req_ready;
    assign resp_valid[g]    = bus_i.resp_valid;
    assign resp_rdata[g]    = bus_i.resp_rdata;
    assign resp_err[g]      = bus_i.resp_err;

    dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4),
      .BASE_ADDR(32'h0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n[g]),
      .bus  (bus_i)
    );
  end

  int checks = 0;
  int errors = 0;
  int cur_k  = 0;

  // Reference memory: one byte per address, little-endian.
  logic [7:0] mem_m [int unsigned];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, cur_k, obs, exp);
    end
  endtask

  // Reference behaviour: returns the expected fault and load value, applies stores.
  task automatic model(input bit we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit err, output logic [31:0] rdata);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    case (size)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    err = (n == 0) || (we && size >= 3'd4);
    if (n != 0 && (addr % n) != 0) err = 1'b1;
    if (addr >= 32'd4096) err = 1'b1;
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[addr + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[addr + i]) << (8 * i));
        if (n < 4 && size < 3'd4) begin
          mask = (32'h1 << (8 * n)) - 32'h1;
          if (((v >> (8 * n - 1)) & 32'h1) != 0) v = v | ~mask;
        end
        rdata = v;
      end
    end
  endtask

  // One full transaction on DUT k, with an optional back-pressure hold of 'hold' cycles.
  task automatic txn(input int k, input bit we, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd, output logic er);
    bit          e_err;
    logic [31:0] e_rd;
    logic [31:0] rd0;
    int          w;
    int          lat;
    model(we, size, addr, wdata, e_err, e_rd);
    @(negedge clk);
    req_we[k] = we; req_size[k] = size; req_addr[k] = addr; req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    w = 0;
    while (!req_ready[k] && w < 20) begin @(negedge clk); w++; end
    check("accept_ready", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    check("ready_low_after_accept", 32'(req_ready[k]), 32'd0);
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin @(negedge clk); lat++; end
    check("latency", 32'(lat), 32'(lat_of(k)));
    rd0 = resp_rdata[k];
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = 1'b1;
      req_addr[k]  = $urandom();
      req_we[k]    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[k]), 32'd1);
      check("hold_rdata", resp_rdata[k], rd0);
      check("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0;
    rd = resp_rdata[k];
    er = resp_err[k];
    check("rdata_vs_model", rd, e_rd);
    check("err_vs_model", 32'(er), 32'(e_err));
    resp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check("valid_drop_after_hs", 32'(resp_valid[k]), 32'd0);
    check("ready_after_hs", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic suite(input int k);
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [2:0]  sz;
    int          r;
    cur_k = k;
    mem_m.delete();
    for (int i = 0; i < 16; i++) txn(k, 1'b1, 3'd2, 32'(4 * i), $urandom(), 0, rd, er);
    for (int i = 0; i < 16; i++) txn(k, 1'b1, 3'd2, 32'hFC0 + 32'(4 * i), $urandom(), 0, rd, er);

    txn(k, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw_err", 32'(er), 32'd0);
    txn(k, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    check("lw_10", rd, 32'hDEADBEEF);
    check("lw_10_err", 32'(er), 32'd0);
    txn(k, 1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er); check("lb_13", rd, 32'hFFFFFFDE);
    txn(k, 1'b0, 3'd4, 32'h13, 32'h0, 0, rd, er); check("lbu_13", rd, 32'h000000DE);
    txn(k, 1'b0, 3'd1, 32'h12, 32'h0, 0, rd, er); check("lh_12", rd, 32'hFFFFDEAD);
    txn(k, 1'b0, 3'd5, 32'h10, 32'h0, 0, rd, er); check("lhu_10", rd, 32'h0000BEEF);
    txn(k, 1'b1, 3'd0, 32'h11, 32'h00000055, 0, rd, er);
    txn(k, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er); check("lw_after_sb", rd, 32'hDEAD55EF);
    txn(k, 1'b1, 3'd1, 32'h12, 32'h00001234, 0, rd, er);
    txn(k, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er); check("lw_after_sh", rd, 32'h123455EF);

    txn(k, 1'b0, 3'd2, 32'h12, 32'h0, 0, rd, er);
    check("lw_misal_err", 32'(er), 32'd1);
    check("lw_misal_rdata", rd, 32'h0);
    txn(k, 1'b1, 3'd1, 32'h13, 32'hFFFF, 0, rd, er); check("sh_misal_err", 32'(er), 32'd1);
    txn(k, 1'b1, 3'd4, 32'h10, 32'hFF, 0, rd, er);   check("sbu_illegal_err", 32'(er), 32'd1);
    txn(k, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);    check("mem_unchanged", rd, 32'h123455EF);
    txn(k, 1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, er);  check("lw_oor_err", 32'(er), 32'd1);
    txn(k, 1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er);    check("size3_err", 32'(er), 32'd1);
    txn(k, 1'b0, 3'd2, 32'hFFC, 32'h0, 0, rd, er);   check("lw_top_ok", 32'(er), 32'd0);

    txn(k, 1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er);    check("lw_held", rd, 32'h123455EF);

    // Reset during WAIT must abort the pending store.
    txn(k, 1'b1, 3'd2, 32'h20, 32'h11223344, 0, rd, er);
    @(negedge clk);
    req_we[k] = 1'b1; req_size[k] = 3'd2; req_addr[k] = 32'h20; req_wdata[k] = 32'hA5A5A5A5;
    req_valid[k] = 1'b1;
    r = 0;
    while (!req_ready[k] && r < 20) begin @(negedge clk); r++; end
    check("rst_accept_ready", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    rst_n[k] = 1'b0;
    #1;
    check("rst_valid_low", 32'(resp_valid[k]), 32'd0);
    check("rst_ready_low", 32'(req_ready[k]), 32'd0);
    @(negedge clk);
    rst_n[k] = 1'b1;
    repeat (lat_of(k) + 2) @(negedge clk);
    check("post_rst_valid", 32'(resp_valid[k]), 32'd0);
    txn(k, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
    check("aborted_store", rd, 32'h11223344);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       a = 32'($urandom_range(0, 63));
      else if (r < 8)  a = 32'hFC0 + 32'($urandom_range(0, 63));
      else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 255));
      else             a = $urandom() | 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) sz = 3'($urandom_range(0, 7));
      else begin
        r = $urandom_range(0, 4);
        sz = (r < 3) ? 3'(r) : 3'(r + 1);
      end
      txn(k, ($urandom_range(0, 2) == 0), sz, a, $urandom(),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 3'd0;
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; resp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      cur_k = k;
      check("reset_req_ready", 32'(req_ready[k]), 32'd0);
      check("reset_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("reset_resp_rdata", resp_rdata[k], 32'h0);
      check("reset_resp_err", 32'(resp_err[k]), 32'd0);
    end
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) suite(k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
